// File: rtl/mod_counter_if.sv
// Signal bundle for one mod_counter stage: control and modulus in, count/cout/tc out.
// The master side drives the controls; the counter itself connects to the slave side.
interface mod_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] modulus;
    logic [WIDTH-1:0] count;
    logic             cout;
    logic             tc;

    modport master (
        output en, up, load, load_val, modulus,
        input  count, cout, tc
    );

    modport slave (
        input  en, up, load, load_val, modulus,
        output count, cout, tc
    );
endinterface

// File: rtl/mod_counter.sv
// Up/down modulo counter (range 0..modulus) with load, registered wrap pulse and a
// combinational terminal count for cascading. MOD_COUNTER_WRAPCNT_EN adds a saturating wrap_cnt.
module mod_counter #(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic           clk,
    input  logic           reset,
    mod_counter_if.slave   bus
`ifdef MOD_COUNTER_WRAPCNT_EN
    ,
    output logic [7:0]     wrap_cnt
`endif
);

    logic [WIDTH-1:0] count_q, count_nxt;
    logic             cout_q, cout_nxt;

    // NOTE: every variable written here gets a default first, so no path infers a latch.
    always_comb begin
        count_nxt = count_q;
        cout_nxt  = 1'b0;
        if (bus.load) begin
            count_nxt = (bus.load_val > bus.modulus) ? bus.modulus : bus.load_val;
        end else if (bus.en) begin
            if (bus.up) begin
                if (count_q >= bus.modulus) begin
                    count_nxt = '0;
                    cout_nxt  = 1'b1;
                end else begin
                    count_nxt = count_q + WIDTH'(1);
                end
            end else begin
                if (count_q == '0) begin
                    count_nxt = bus.modulus;
                    cout_nxt  = 1'b1;
                end else if (count_q > bus.modulus) begin
                    // Out-of-range after the modulus was lowered: snap down without a borrow.
                    count_nxt = bus.modulus;
                end else begin
                    count_nxt = count_q - WIDTH'(1);
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= INIT;
            cout_q  <= 1'b0;
        end else begin
            count_q <= count_nxt;
            cout_q  <= cout_nxt;
        end
    end

    assign bus.count = count_q;
    assign bus.cout  = cout_q;
    assign bus.tc    = bus.en & ~bus.load &
                       (bus.up ? (count_q >= bus.modulus) : (count_q == '0));

`ifdef MOD_COUNTER_WRAPCNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrap_cnt <= 8'd0;
        end else if (bus.load) begin
            wrap_cnt <= 8'd0;
        end else if (cout_nxt && (wrap_cnt != 8'hFF)) begin
            wrap_cnt <= wrap_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mod_counter.sv
// Directed vector bench for mod_counter: table of single-cycle vectors plus
// hand sequences for reset, a two-stage cascade and the optional wrap counter.
module tb_mod_counter;

    localparam int W = 4;

    logic clk;
    logic reset;

    mod_counter_if #(.WIDTH(W)) bus ();
    mod_counter_if #(.WIDTH(W)) if0 ();
    mod_counter_if #(.WIDTH(W)) if1 ();

    assign if1.en = if0.tc;

`ifdef MOD_COUNTER_WRAPCNT_EN
    logic [7:0] wrap_cnt, wrap_cnt0, wrap_cnt1;
    mod_counter #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus), .wrap_cnt(wrap_cnt));
    mod_counter #(.WIDTH(W)) st0 (.clk(clk), .reset(reset), .bus(if0), .wrap_cnt(wrap_cnt0));
    mod_counter #(.WIDTH(W)) st1 (.clk(clk), .reset(reset), .bus(if1), .wrap_cnt(wrap_cnt1));
`else
    mod_counter #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));
    mod_counter #(.WIDTH(W)) st0 (.clk(clk), .reset(reset), .bus(if0));
    mod_counter #(.WIDTH(W)) st1 (.clk(clk), .reset(reset), .bus(if1));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic         en;
        logic         up;
        logic         load;
        logic [W-1:0] load_val;
        logic [W-1:0] modulus;
        logic [W-1:0] exp_count;
        logic         exp_cout;
        logic         exp_tc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic en, logic up, logic load, int lv, int md,
                                int ec, logic eco, logic etc_);
        vec_t v;
        v.en = en; v.up = up; v.load = load;
        v.load_val = W'(lv); v.modulus = W'(md);
        v.exp_count = W'(ec); v.exp_cout = eco; v.exp_tc = etc_;
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses1, pulses0, pulse_cyc;

        // Count up mod 9 from reset: 1..9, 0 (wrap), 1, 2
        for (int i = 1; i <= 9; i++) vecs.push_back(mk(1, 1, 0, 0, 9, i, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 9, 0, 1, 1));
        vecs.push_back(mk(1, 1, 0, 0, 9, 1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 9, 2, 0, 0));
        // Load 0, then count down mod 5: 5,4,3,2,1,0,5
        vecs.push_back(mk(0, 0, 1, 0, 5, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 5, 5, 1, 1));
        for (int i = 4; i >= 0; i--) vecs.push_back(mk(1, 0, 0, 0, 5, i, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 5, 5, 1, 1));
        // Load clamp, load beats en, hold
        vecs.push_back(mk(0, 0, 1, 12, 9, 9, 0, 0));
        vecs.push_back(mk(1, 1, 1, 3, 9, 3, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 9, 3, 0, 0));
        // Modulus lowered below count: up recovers to 0 with cout, down to modulus without
        vecs.push_back(mk(0, 0, 1, 8, 9, 8, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 5, 0, 1, 1));
        vecs.push_back(mk(0, 0, 1, 8, 9, 8, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 5, 5, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 5, 4, 0, 0));
        vecs.push_back(mk(0, 0, 1, 5, 5, 5, 0, 0));
        // modulus == 0
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 1));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 7, 0, 0, 0, 0));
        // modulus == 15: natural binary wrap both ways
        vecs.push_back(mk(0, 0, 1, 14, 15, 14, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 15, 15, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 15, 0, 1, 1));
        vecs.push_back(mk(1, 0, 0, 0, 15, 15, 1, 1));
        vecs.push_back(mk(1, 0, 0, 0, 15, 14, 0, 0));

        reset = 1'b0;
        bus.en = 0; bus.up = 0; bus.load = 0; bus.load_val = '0; bus.modulus = '0;
        if0.en = 0; if0.up = 1; if0.load = 0; if0.load_val = '0; if0.modulus = 4'd9;
        if1.up = 1; if1.load = 0; if1.load_val = '0; if1.modulus = 4'd4;

        repeat (2) @(posedge clk);
        #1;
        check("reset_count", 32'(bus.count), 32'd0);
        check("reset_cout", 32'(bus.cout), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        foreach (vecs[i]) begin
            bus.en = vecs[i].en; bus.up = vecs[i].up; bus.load = vecs[i].load;
            bus.load_val = vecs[i].load_val; bus.modulus = vecs[i].modulus;
            #1;
            check($sformatf("vec%0d_tc", i), 32'(bus.tc), 32'(vecs[i].exp_tc));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_count", i), 32'(bus.count), 32'(vecs[i].exp_count));
            check($sformatf("vec%0d_cout", i), 32'(bus.cout), 32'(vecs[i].exp_cout));
        end

        // Async reset mid-count at count=7, then first edge after release gives INIT+1
        bus.load = 1; bus.load_val = 4'd7; bus.modulus = 4'd9; bus.en = 0; bus.up = 1;
        @(posedge clk); #1;
        check("pre_reset_count", 32'(bus.count), 32'd7);
        bus.load = 0; bus.en = 1;
        #3 reset = 1'b0;
        #1;
        check("async_reset_count", 32'(bus.count), 32'd0);
        check("async_reset_cout", 32'(bus.cout), 32'd0);
        @(posedge clk); #1;
        check("reset_held_count", 32'(bus.count), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("post_release_count", 32'(bus.count), 32'd1);

        // Reset while cout is high clears it immediately
        bus.load = 1; bus.load_val = 4'd9; bus.en = 0;
        @(posedge clk); #1;
        bus.load = 0; bus.en = 1;
        @(posedge clk); #1;
        check("wrap_cout_before_reset", 32'(bus.cout), 32'd1);
        bus.en = 0;
        #2 reset = 1'b0;
        #1;
        check("async_reset_clears_cout", 32'(bus.cout), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Cascade: stage0 mod 9 (10 states), stage1 modulus 4 (5 states), tc0 -> en1
        if0.load = 1; if1.load = 1; if0.en = 0;
        @(posedge clk); #1;
        if0.load = 0; if1.load = 0; if0.en = 1;
        pulses0 = 0; pulses1 = 0; pulse_cyc = 0;
        for (int c = 1; c <= 50; c++) begin
            @(posedge clk); #1;
            if (if0.cout) pulses0++;
            if (if1.cout) begin
                pulses1++;
                pulse_cyc = c;
            end
            if (c == 40) check("cascade_stage1_at40", 32'(if1.count), 32'd4);
        end
        check("cascade_stage0_count", 32'(if0.count), 32'd0);
        check("cascade_stage1_count", 32'(if1.count), 32'd0);
        check("cascade_stage0_pulses", 32'(pulses0), 32'd5);
        check("cascade_stage1_pulses", 32'(pulses1), 32'd1);
        check("cascade_stage1_pulse_cycle", 32'(pulse_cyc), 32'd50);
        if0.en = 0;

`ifdef MOD_COUNTER_WRAPCNT_EN
        bus.load = 1; bus.load_val = 4'd0; bus.modulus = 4'd0; bus.en = 0; bus.up = 1;
        @(posedge clk); #1;
        check("wrapcnt_after_load", 32'(wrap_cnt), 32'd0);
        bus.load = 0; bus.en = 1;
        repeat (10) @(posedge clk);
        #1;
        check("wrapcnt_10", 32'(wrap_cnt), 32'd10);
        repeat (290) @(posedge clk);
        #1;
        check("wrapcnt_saturated", 32'(wrap_cnt), 32'd255);
        bus.load = 1; bus.en = 0;
        @(posedge clk); #1;
        check("wrapcnt_load_clear", 32'(wrap_cnt), 32'd0);
        bus.load = 0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
